// File: rtl/daq_rx_elastic_buffer.sv
// Elastic buffer: drops incoming clock-correction words, queues the rest, re-inserts CC while priming/underflowing.
// Status counters and edge registers are built only when DAQ_RX_EB_STATUS_EN is defined.
module daq_rx_elastic_buffer #(
    parameter int                 BYTES   = 2,
    parameter int                 DEPTH   = 16,
    parameter int                 PREFILL = 4,
    parameter logic [8*BYTES-1:0] CC_WORD = 16'hdcfb,
    parameter int                 CNT_W   = 16
) (
    input  logic                         usr_clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [BYTES-1:0]             in_notintable,
    input  logic [BYTES-1:0]             in_chariscomma,
    input  logic [BYTES-1:0]             in_charisk,
    input  logic [8*BYTES-1:0]           in_data,
    output logic [BYTES-1:0]             out_notintable,
    output logic [BYTES-1:0]             out_chariscomma,
    output logic [BYTES-1:0]             out_charisk,
    output logic [8*BYTES-1:0]           out_data,
    output logic                         out_fill,
    output logic [$clog2(DEPTH):0]       level,
    input  logic                         almost_full,
    input  logic                         ready,
    input  logic                         clr_cnt,
    output logic [CNT_W-1:0]             cc_drop_cnt,
    output logic [CNT_W-1:0]             underflow_cnt,
    output logic [CNT_W-1:0]             overflow_cnt,
    output logic [CNT_W-1:0]             almost_full_cnt,
    output logic [CNT_W-1:0]             ready_drop_cnt,
    output logic [0:0]                   dbg_state
);

    localparam int DW = 8 * BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 3 * BYTES + DW;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [EW-1:0] CC_ENTRY = {{BYTES{1'b0}}, {BYTES{1'b0}}, {BYTES{1'b1}}, CC_WORD};

    // Handshake: in_valid is a pure strobe with no back-pressure; each strobed word is
    // stored, dropped as CC, or counted as overflow in that same cycle. The output side
    // emits one word every cycle; ready/almost_full only feed the status counters.

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] out_q, out_d;
    logic          out_fill_q, out_fill_d;

    logic is_cc, wr_en, rd_en, underflow, overflow;
    logic [EW-1:0] in_entry;

    assign in_entry  = {in_notintable, in_chariscomma, in_charisk, in_data};
    assign is_cc     = in_valid && (&in_charisk) && (in_data == CC_WORD);
    assign rd_en     = (state_q == ST_RUN) && (level_q != '0);
    // Underflow uses the pre-update level, so a same-cycle write cannot rescue it.
    assign underflow = (state_q == ST_RUN) && (level_q == '0);
    assign wr_en     = in_valid && !is_cc && ((level_q != LW'(DEPTH)) || rd_en);
    assign overflow  = in_valid && !is_cc && !wr_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PRIME: if (level_q >= LW'(PREFILL)) state_d = ST_RUN;
            ST_RUN:   if (underflow)               state_d = ST_PRIME;
            default:                               state_d = ST_PRIME;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        out_d      = CC_ENTRY;
        out_fill_d = 1'b1;
        if (rd_en) begin
            out_d      = mem_q[rd_ptr_q];
            out_fill_d = 1'b0;
        end
    end

    always_ff @(posedge usr_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge usr_clk) begin
        if (!reset_n) begin
            state_q    <= ST_PRIME;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_q      <= CC_ENTRY;
            out_fill_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            out_q      <= out_d;
            out_fill_q <= out_fill_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign {out_notintable, out_chariscomma, out_charisk, out_data} = out_q;
    assign out_fill  = out_fill_q;
    assign level     = level_q;
    assign dbg_state = state_q;

`ifdef DAQ_RX_EB_STATUS_EN
    logic             af_prev_q, rdy_prev_q;
    logic [CNT_W-1:0] cc_drop_q, cc_drop_d;
    logic [CNT_W-1:0] underflow_q, underflow_d;
    logic [CNT_W-1:0] overflow_q, overflow_d;
    logic [CNT_W-1:0] af_cnt_q, af_cnt_d;
    logic [CNT_W-1:0] rdy_drop_q, rdy_drop_d;

    // Saturating increment; clear wins over a same-cycle event.
    function automatic logic [CNT_W-1:0] sat_bump(input logic [CNT_W-1:0] cnt,
                                                  input logic hit, input logic clr);
        if (clr) return '0;
        if (hit && (cnt != {CNT_W{1'b1}})) return cnt + 1'b1;
        return cnt;
    endfunction

    always_comb begin
        cc_drop_d   = sat_bump(cc_drop_q,   is_cc,                     clr_cnt);
        underflow_d = sat_bump(underflow_q, underflow,                 clr_cnt);
        overflow_d  = sat_bump(overflow_q,  overflow,                  clr_cnt);
        af_cnt_d    = sat_bump(af_cnt_q,    almost_full && !af_prev_q, clr_cnt);
        rdy_drop_d  = sat_bump(rdy_drop_q,  !ready && rdy_prev_q,      clr_cnt);
    end

    always_ff @(posedge usr_clk) begin
        if (!reset_n) begin
            af_prev_q   <= 1'b0;
            rdy_prev_q  <= 1'b0;
            cc_drop_q   <= '0;
            underflow_q <= '0;
            overflow_q  <= '0;
            af_cnt_q    <= '0;
            rdy_drop_q  <= '0;
        end else begin
            af_prev_q   <= almost_full;
            rdy_prev_q  <= ready;
            cc_drop_q   <= cc_drop_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            af_cnt_q    <= af_cnt_d;
            rdy_drop_q  <= rdy_drop_d;
        end
    end

    assign cc_drop_cnt     = cc_drop_q;
    assign underflow_cnt   = underflow_q;
    assign overflow_cnt    = overflow_q;
    assign almost_full_cnt = af_cnt_q;
    assign ready_drop_cnt  = rdy_drop_q;
`else
    logic unused_status;
    assign unused_status   = ^{almost_full, ready, clr_cnt, overflow};
    assign cc_drop_cnt     = '0;
    assign underflow_cnt   = '0;
    assign overflow_cnt    = '0;
    assign almost_full_cnt = '0;
    assign ready_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_daq_rx_elastic_buffer.sv
// Directed bench for daq_rx_elastic_buffer (DEPTH=16, PREFILL=4, CNT_W=4); counter expectations follow DAQ_RX_EB_STATUS_EN.
module tb_daq_rx_elastic_buffer;

    localparam int BYTES = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int EW    = 3 * BYTES + DW;
    localparam logic [15:0]   CC       = 16'hdcfb;
    localparam logic [EW-1:0] CC_ENTRY = {2'b00, 2'b00, 2'b11, 16'hdcfb};
`ifdef DAQ_RX_EB_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    // clock / reset
    logic usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;
    logic reset_n;

    logic             in_valid;
    logic [1:0]       in_notintable, in_chariscomma, in_charisk;
    logic [DW-1:0]    in_data;
    logic [1:0]       out_notintable, out_chariscomma, out_charisk;
    logic [DW-1:0]    out_data;
    logic             out_fill;
    logic [4:0]       level;
    logic             almost_full, ready, clr_cnt;
    logic [CNT_W-1:0] cc_drop_cnt, underflow_cnt, overflow_cnt, almost_full_cnt, ready_drop_cnt;
    logic [0:0]       dbg_state;

    daq_rx_elastic_buffer #(
        .BYTES(BYTES), .DEPTH(DEPTH), .PREFILL(4), .CC_WORD(16'hdcfb), .CNT_W(CNT_W)
    ) dut (
        .usr_clk(usr_clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_notintable(in_notintable), .in_chariscomma(in_chariscomma),
        .in_charisk(in_charisk), .in_data(in_data),
        .out_notintable(out_notintable), .out_chariscomma(out_chariscomma),
        .out_charisk(out_charisk), .out_data(out_data), .out_fill(out_fill),
        .level(level), .almost_full(almost_full), .ready(ready), .clr_cnt(clr_cnt),
        .cc_drop_cnt(cc_drop_cnt), .underflow_cnt(underflow_cnt),
        .overflow_cnt(overflow_cnt), .almost_full_cnt(almost_full_cnt),
        .ready_drop_cnt(ready_drop_cnt), .dbg_state(dbg_state)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    bit            push_en = 1'b1;
    int            checks  = 0;
    int            errors  = 0;

    function automatic logic [31:0] ecnt(input int n);
        if (!STATUS) return 32'd0;
        return (n > 15) ? 32'd15 : 32'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; every output word is checked against the queue or the CC pattern.
    task automatic step();
        logic [EW-1:0] got, exp;
        @(posedge usr_clk); #1;
        got = {out_notintable, out_chariscomma, out_charisk, out_data};
        if (out_fill === 1'b0) begin
            exp = 'x;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            chk("out_word", 32'(got), 32'(exp));
        end else begin
            chk("cc_insert", 32'(got), 32'(CC_ENTRY));
        end
    endtask

    task automatic drive(input logic [1:0] nit, input logic [1:0] com,
                         input logic [1:0] k, input logic [15:0] d);
        in_valid = 1'b1; in_notintable = nit; in_chariscomma = com;
        in_charisk = k; in_data = d;
        if (push_en && !(k == 2'b11 && d == CC)) exp_q.push_back({nit, com, k, d});
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 0; in_notintable = 0; in_chariscomma = 0; in_charisk = 0; in_data = 0;
        almost_full = 0; ready = 1; clr_cnt = 0; reset_n = 0;
        repeat (2) @(posedge usr_clk);
        #1;
        reset_n = 1;
        chk("rst_level", 32'(level), 0);
        chk("rst_fill", 32'(out_fill), 1);
        chk("rst_word", 32'({out_notintable, out_chariscomma, out_charisk, out_data}), 32'(CC_ENTRY));
        chk("rst_state", 32'(dbg_state), 0);
        chk("rst_cc_drop", 32'(cc_drop_cnt), 0);
        chk("rst_underflow", 32'(underflow_cnt), 0);
        chk("rst_overflow", 32'(overflow_cnt), 0);
        chk("rst_af", 32'(almost_full_cnt), 0);
        chk("rst_rdy", 32'(ready_drop_cnt), 0);

        // prime with four words, then drain to underflow with a write in the underflow cycle
        drive(2'b00, 2'b00, 2'b00, 16'h0001);
        drive(2'b00, 2'b01, 2'b01, 16'h0002);
        drive(2'b10, 2'b00, 2'b00, 16'h0003);
        drive(2'b00, 2'b00, 2'b00, 16'h0004);
        chk("t1_level4", 32'(level), 4);
        chk("t1_fill_prime", 32'(out_fill), 1);
        chk("t1_state_prime", 32'(dbg_state), 0);
        idle(1);
        chk("t1_state_run", 32'(dbg_state), 1);
        chk("t1_level_hold", 32'(level), 4);
        chk("t1_fill_before", 32'(out_fill), 1);
        idle(1);
        chk("t1_first_out", 32'(out_data), 32'h0001);
        chk("t1_first_fill", 32'(out_fill), 0);
        chk("t1_level3", 32'(level), 3);
        idle(3);
        chk("t1_last_out", 32'(out_data), 32'h0004);
        chk("t1_level0", 32'(level), 0);
        drive(2'b00, 2'b00, 2'b00, 16'h0005);
        chk("t1_uf_fill", 32'(out_fill), 1);
        chk("t1_uf_state", 32'(dbg_state), 0);
        chk("t1_uf_level", 32'(level), 1);
        chk("t1_uf_cnt", 32'(underflow_cnt), ecnt(1));
        chk("t1_queue", 32'(exp_q.size()), 1);

        // CC words interleaved with data, including a near-CC data word
        drive(2'b00, 2'b00, 2'b00, 16'h0011);
        drive(2'b00, 2'b00, 2'b11, CC);
        drive(2'b01, 2'b00, 2'b00, 16'h0012);
        drive(2'b00, 2'b00, 2'b11, CC);
        drive(2'b00, 2'b00, 2'b11, CC);
        drive(2'b00, 2'b00, 2'b10, CC);
        chk("t2_level4", 32'(level), 4);
        drive(2'b00, 2'b00, 2'b00, 16'h0013);
        drive(2'b00, 2'b00, 2'b00, 16'h0014);
        chk("t2_level5", 32'(level), 5);
        chk("t2_out5", 32'(out_data), 32'h0005);
        idle(6);
        chk("t2_drained", 32'(exp_q.size()), 0);
        chk("t2_level0", 32'(level), 0);
        chk("t2_state", 32'(dbg_state), 0);
        chk("t2_cc_drop", 32'(cc_drop_cnt), ecnt(3));
        chk("t2_underflow", 32'(underflow_cnt), ecnt(2));

        // almost_full 0->1->0->1, ready 1->0->1->0
        almost_full = 1; ready = 0; step();
        almost_full = 0; ready = 1; step();
        almost_full = 1; ready = 0; step();
        idle(2);
        chk("t4_af_cnt", 32'(almost_full_cnt), ecnt(2));
        chk("t4_rdy_cnt", 32'(ready_drop_cnt), ecnt(2));
        almost_full = 0; ready = 1; idle(2);
        chk("t4_af_stable", 32'(almost_full_cnt), ecnt(2));
        almost_full = 1; ready = 0; clr_cnt = 1; step();
        clr_cnt = 0; idle(2);
        chk("t4_clr_af", 32'(almost_full_cnt), 0);
        chk("t4_clr_rdy", 32'(ready_drop_cnt), 0);
        chk("t4_clr_cc", 32'(cc_drop_cnt), 0);
        chk("t4_clr_uf", 32'(underflow_cnt), 0);
        almost_full = 0; ready = 1; idle(1);

        // 2^CNT_W+5 CC words saturate the drop counter
        repeat (21) drive(2'b00, 2'b00, 2'b11, CC);
        idle(1);
        chk("t5_cc_sat", 32'(cc_drop_cnt), ecnt(21));
        chk("t5_level", 32'(level), 0);
        chk("t5_state", 32'(dbg_state), 0);

        // overflow with reads blocked, then reset mid-stream
        force dut.state_q = 1'b0;
        push_en = 1'b0;
        for (int i = 0; i < 20; i++) drive(2'b00, 2'b00, 2'b00, 16'h0100 + 16'(i));
        idle(1);
        chk("t6_level_full", 32'(level), 16);
        chk("t6_overflow", 32'(overflow_cnt), ecnt(4));
        release dut.state_q;
        reset_n = 0;
        @(posedge usr_clk); #1;
        reset_n = 1;
        chk("t6_rst_level", 32'(level), 0);
        chk("t6_rst_fill", 32'(out_fill), 1);
        chk("t6_rst_state", 32'(dbg_state), 0);
        chk("t6_rst_overflow", 32'(overflow_cnt), 0);
        exp_q.delete();
        push_en = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 16'h0a01);
        drive(2'b00, 2'b00, 2'b00, 16'h0a02);
        drive(2'b00, 2'b00, 2'b00, 16'h0a03);
        drive(2'b00, 2'b00, 2'b00, 16'h0a04);
        idle(2);
        chk("t6_resume_first", 32'(out_data), 32'h0a01);
        idle(4);
        chk("t6_resume_drained", 32'(exp_q.size()), 0);
        chk("t6_resume_uf", 32'(underflow_cnt), ecnt(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
